// File: rtl/bus_pkg.sv
// Shared bus package.
// Holds the slave-side state type and the default address/data widths
// used by the slave port, the master port and the address decoder.
package bus_pkg;

  // Default number of in-slave address bits sent serially after selection.
  localparam int BUS_ADDR_WIDTH = 12;

  // Default data word width.
  localparam int BUS_DATA_WIDTH = 8;

  // Slave port transaction states.
  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    WRITE,
    RWAIT,
    RDATA
  } slave_state_t;

endpackage

// File: rtl/slave_bram.sv
// Single-port block RAM for the slave port.
// A write happens on the rising edge when we is high. The read is synchronous
// with one cycle of latency: rdata shows mem[addr] from the previous edge.
// Memory contents have no reset.
//
// Ports:
//   CLK    in   1      clock
//   we     in   1      write enable
//   addr   in   AW     word address
//   wdata  in   WIDTH  write data
//   rdata  out  WIDTH  registered read data
module slave_bram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Write-first is not needed here: a read in the write cycle returns old data.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave port with a local memory.
// After selection, the port receives an ADDR_WIDTH-bit address LSB first on
// B_BUS_OUT. For a write, it then receives DATA_WIDTH data bits and writes
// them in one cycle. For a read, it fetches the word and returns it LSB first
// on S_BUS_IN while S_RVALID is high. Addresses at or above MEM_DEPTH drop the
// write or read back as zero.
//
// Ports:
//   CLK        in   1  clock, all state on the rising edge
//   RSTN       in   1  asynchronous active-low reset
//   S_SEL      in   1  slave select from the address decoder
//   B_UTIL     in   1  bus in use by the granted master
//   B_MODE     in   1  1 = write, 0 = read; sampled when the transaction starts
//   B_BUS_OUT  in   1  serial master-to-slave bit, LSB first
//   S_READY    out  1  slave idle and able to accept a transaction
//   S_RVALID   out  1  S_BUS_IN carries a valid read bit
//   S_BUS_IN   out  1  serial slave-to-master bit, LSB first
module slave_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic S_SEL,
  input  logic B_UTIL,
  input  logic B_MODE,
  input  logic B_BUS_OUT,
  output logic S_READY,
  output logic S_RVALID,
  output logic S_BUS_IN
);

  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  slave_state_t state, state_next;

  logic [CNT_W-1:0]      bit_cnt;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [ADDR_WIDTH-1:0] addr_shift;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  mode_reg;
  logic                  in_range;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr_full;
  logic [MEM_AW-1:0]     mem_addr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The address register value after this cycle's bit is shifted in.
  // Bits arrive LSB first, so each new bit enters at the top.
  assign addr_shift = {B_BUS_OUT, addr_reg[ADDR_WIDTH-1:1]};

  assign in_range = ({1'b0, addr_reg} < (ADDR_WIDTH + 1)'(MEM_DEPTH));

  // During ADDR, the RAM sees the address being assembled. On the last
  // address edge, the read is therefore issued with the complete address, and
  // its data is ready in the single RWAIT cycle.
  assign mem_addr_full = (state == ADDR) ? addr_shift : addr_reg;
  assign mem_addr      = mem_addr_full[MEM_AW-1:0];

  slave_bram #(
    .DEPTH(MEM_DEPTH),
    .WIDTH(DATA_WIDTH),
    .AW   (MEM_AW)
  ) u_bram (
    .CLK  (CLK),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(data_reg),
    .rdata(mem_rdata)
  );

  // Next-state and output decode. Outputs depend only on the current state,
  // so an asynchronous reset forces them to their idle values at once.
  always_comb begin
    state_next = state;
    S_READY    = 1'b0;
    S_RVALID   = 1'b0;
    S_BUS_IN   = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        S_READY = 1'b1;
        if (S_SEL && B_UTIL) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (!B_UTIL) begin
          state_next = IDLE;
        end else if (bit_cnt == ADDR_LAST) begin
          state_next = mode_reg ? WDATA : RWAIT;
        end
      end
      WDATA: begin
        if (!B_UTIL) begin
          state_next = IDLE;
        end else if (bit_cnt == DATA_LAST) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        mem_we     = in_range;
        state_next = IDLE;
      end
      RWAIT: begin
        state_next = RDATA;
      end
      RDATA: begin
        S_RVALID = 1'b1;
        S_BUS_IN = data_reg[0];
        if (bit_cnt == DATA_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register and datapath. The bit counter clears on every state
  // change and counts only inside a shifting state. It is never wrapped
  // arithmetically; the state exit ends each count.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      addr_reg <= '0;
      data_reg <= '0;
      mode_reg <= 1'b0;
    end else begin
      state <= state_next;

      if (state_next != state) begin
        bit_cnt <= '0;
      end else if (state == ADDR || state == WDATA || state == RDATA) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (S_SEL && B_UTIL) begin
            mode_reg <= B_MODE;
          end
        end
        ADDR: begin
          if (B_UTIL) begin
            addr_reg <= addr_shift;
          end
        end
        WDATA: begin
          if (B_UTIL) begin
            data_reg <= {B_BUS_OUT, data_reg[DATA_WIDTH-1:1]};
          end
        end
        RWAIT: begin
          data_reg <= in_range ? mem_rdata : '0;
        end
        RDATA: begin
          data_reg <= data_reg >> 1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning in-slave address bits received serially after slave selection.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data word width.
REQ-003 SHALL have parameter MEM_DEPTH, default 4096, meaning words in local memory (2**ADDR_WIDTH max).
REQ-004 SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- CLK  in  1  sole clock; all state on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- S_SEL  in  1  slave select, one bit of the address decoder select vector.
- B_UTIL  in  1  bus in use by the granted master.
- B_MODE  in  1  1 = write, 0 = read; sampled at start.
- B_BUS_OUT  in  1  serial master-to-slave bit, LSB first.
- S_READY  out  1  slave idle and able to accept a transaction.
- S_RVALID  out  1  S_BUS_IN carries a valid read bit.
- S_BUS_IN  out  1  serial slave-to-master bit, LSB first.

Function
REQ-005 SHALL implement states IDLE, ADDR, WDATA, WRITE, RWAIT, RDATA.
REQ-006 SHALL in IDLE drive S_READY=1, S_RVALID=0, S_BUS_IN=0.
REQ-007 SHALL leave IDLE for ADDR on the first edge with S_SEL=1 and B_UTIL=1, latching B_MODE on that edge.
REQ-008 SHALL in ADDR shift one B_BUS_OUT bit per cycle into the address register, LSB first, for exactly ADDR_WIDTH cycles, using a bit counter cleared on state entry.
REQ-009 SHALL after the last address bit go to WDATA if latched mode=1, else RWAIT.
REQ-010 SHALL in WDATA shift DATA_WIDTH bits LSB first, then go to WRITE.
REQ-011 SHALL in WRITE assert the memory write enable for exactly one cycle at the received address, then return to IDLE.
REQ-012 SHALL in RWAIT issue a synchronous memory read with 1-cycle latency, load the result into the shift register, then go to RDATA.
REQ-013 SHALL in RDATA drive S_RVALID=1 and S_BUS_IN = shift register bit 0 for DATA_WIDTH cycles, shifting right each cycle, then return to IDLE.
REQ-014 SHALL hold S_READY=0 in every state other than IDLE.
REQ-015 SHALL abort to IDLE with no memory write when B_UTIL=0 in any cycle of ADDR or WDATA; partial shift contents are discarded.
REQ-016 SHALL complete RWAIT/RDATA regardless of B_UTIL or S_SEL, since the master is waiting on read data.
REQ-017 SHALL ignore S_SEL and B_MODE outside IDLE.
REQ-018 SHALL treat an address at or above MEM_DEPTH as follows: a write is dropped, and a read returns all zeros.
REQ-019 SHALL wrap the bit counter only by state exit, never modulo.
REQ-020 SHALL return to IDLE directly from WRITE or RDATA; it SHALL NOT accept a back-to-back transaction in the same cycle.

Reset
REQ-021 SHALL on RSTN=0 immediately force state=IDLE, counter=0, address/data registers=0, S_READY=1, S_RVALID=0, S_BUS_IN=0.
REQ-022 SHALL leave memory contents unchanged by reset; reset mid-WRITE suppresses the write if asserted before that edge.

Structure
REQ-023 SHALL take the state enum type and default ADDR_WIDTH/DATA_WIDTH constants from the shared bus package, used also by master port and address decoder.
REQ-024 SHALL instantiate one sub-module slave_bram (single-port, synchronous read, 1-cycle latency, write-enable, parameterized depth/width).

Verification
REQ-025 Write: S_SEL=B_UTIL=1, B_MODE=1, address 0x005 then data 0xA5 serial LSB first -> single write, memory[0x005]=0xA5, S_READY high 1 cycle after WRITE.
REQ-026 Read after write: read of 0x005 -> after 1 RWAIT cycle, S_RVALID high 8 cycles, S_BUS_IN = 1,0,1,0,0,1,0,1.
REQ-027 Abort: write begun, B_UTIL dropped after 3 data bits -> next cycle IDLE, memory[0x005] unchanged, S_READY=1.
REQ-028 Reset mid-RDATA: RSTN low at 4th read bit -> S_RVALID=0, S_BUS_IN=0, S_READY=1 same cycle, memory intact.
REQ-029 Out-of-range: MEM_DEPTH=2048, write 0x800=0xFF then read 0x800 -> no write, read returns 0x00.
REQ-030 Deselected: S_SEL=0 with B_UTIL=1 and bus traffic for 30 cycles -> state stays IDLE, S_RVALID never asserted.
